// File: rtl/coin_change_dispenser_if.sv
// Request, refill, hopper and status signals between the vend controller, the dispenser and the coin hopper.
interface coin_change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             refill;
    logic [CNT_W-1:0] refill_5;
    logic [CNT_W-1:0] refill_10;
    logic             out_5;
    logic             out_10;
    logic             hopper_ack;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] cnt_5;
    logic [CNT_W-1:0] cnt_10;
    logic             low_stock;

    modport master (
        output req_valid, req_amount, refill, refill_5, refill_10, hopper_ack,
        input  req_ready, out_5, out_10, done, err, cnt_5, cnt_10, low_stock
    );

    modport slave (
        input  req_valid, req_amount, refill, refill_5, refill_10, hopper_ack,
        output req_ready, out_5, out_10, done, err, cnt_5, cnt_10, low_stock
    );
endinterface

// File: rtl/coin_change_dispenser.sv
// Greedy change dispenser (10s then 5s) with coin inventory; COIN_LOW_WARN_EN adds the low_stock flag.
// Latency: 1 check cycle + (PULSE_LEN + ack wait + GAP_LEN) per coin + 1 finish cycle.
// Backpressure: req_ready only in IDLE; refill ignored outside IDLE; missing hopper ack aborts after ACK_TIMEOUT.
module coin_change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 8,
    parameter int INIT_5      = 20,
    parameter int INIT_10     = 20,
    parameter int PULSE_LEN   = 4,
    parameter int GAP_LEN     = 2,
    parameter int ACK_TIMEOUT = 255,
    parameter int LOW_THRESH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    coin_change_dispenser_if.slave  bus
);
    localparam int TMAX  = (ACK_TIMEOUT > PULSE_LEN) ?
                           ((ACK_TIMEOUT > GAP_LEN) ? ACK_TIMEOUT : GAP_LEN) :
                           ((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN);
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int WW    = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

    typedef enum logic [2:0] {IDLE, CHECK, PULSE, WAIT_ACK, GAP, FIN} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [AMT_W-1:0] amt_q, n10_q, n5_q;
    logic [CNT_W-1:0] c5_q, c10_q;
    logic             ack_seen_q, err_q;
    logic             err_set, load, ack_take;
    logic [WW-1:0]    want10, take10, rem, need5;
    logic             reject;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Greedy split of the held amount against the stock seen in CHECK.
    always_comb begin
        want10 = WW'(amt_q) / WW'(10);
        take10 = (want10 < WW'(c10_q)) ? want10 : WW'(c10_q);
        rem    = WW'(amt_q) - take10 * WW'(10);
        need5  = rem / WW'(5);
        reject = ((WW'(amt_q) % WW'(5)) != '0) || (need5 > WW'(c5_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        err_set  = 1'b0;
        load     = 1'b0;
        ack_take = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = CHECK;
            CHECK: begin
                tmr_d = '0;
                if (reject) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (amt_q == '0) begin
                    state_d = FIN;
                end else begin
                    load    = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (tmr_q == TMR_W'(PULSE_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus.hopper_ack || ack_seen_q) begin
                    ack_take = 1'b1;
                    tmr_d    = '0;
                    state_d  = GAP;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == TMR_W'(GAP_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = ((n10_q != '0) || (n5_q != '0)) ? PULSE : FIN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q      <= '0;
            amt_q      <= '0;
            n10_q      <= '0;
            n5_q       <= '0;
            c5_q       <= CNT_W'(INIT_5);
            c10_q      <= CNT_W'(INIT_10);
            ack_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_set;
            if (state_q == IDLE) begin
                if (bus.req_valid) amt_q <= bus.req_amount;
                if (bus.refill) begin
                    c5_q  <= sat_add(c5_q, bus.refill_5);
                    c10_q <= sat_add(c10_q, bus.refill_10);
                end
            end
            if (load) begin
                n10_q <= AMT_W'(take10);
                n5_q  <= AMT_W'(need5);
            end
            // An ack that arrives while the pulse is still high is remembered for WAIT_ACK.
            if (ack_take || load)                       ack_seen_q <= 1'b0;
            else if (state_q == PULSE && bus.hopper_ack) ack_seen_q <= 1'b1;
            if (ack_take) begin
                if (n10_q != '0) begin
                    n10_q <= n10_q - 1'b1;
                    c10_q <= c10_q - 1'b1;
                end else begin
                    n5_q <= n5_q - 1'b1;
                    c5_q <= c5_q - 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.out_10    = (state_q == PULSE) && (n10_q != '0);
    assign bus.out_5     = (state_q == PULSE) && (n10_q == '0);
    assign bus.done      = (state_q == FIN);
    assign bus.err       = err_q;
    assign bus.cnt_5     = c5_q;
    assign bus.cnt_10    = c10_q;

`ifdef COIN_LOW_WARN_EN
    logic low_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) low_q <= 1'b0;
        else      low_q <= (c5_q < CNT_W'(LOW_THRESH)) || (c10_q < CNT_W'(LOW_THRESH));
    end
    assign bus.low_stock = low_q;
`else
    assign bus.low_stock = 1'b0;
`endif
endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: directed scenarios plus randomized requests checked against an arithmetic inventory model.
module tb_coin_change_dispenser;
    localparam int AMT_W = 8, CNT_W = 8, INIT_5 = 20, INIT_10 = 20;
    localparam int PULSE_LEN = 4, GAP_LEN = 2, ACK_TIMEOUT = 255, LOW_THRESH = 3;
`ifdef COIN_LOW_WARN_EN
    localparam bit LOW_EN = 1'b1;
`else
    localparam bit LOW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    coin_change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus();

    coin_change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_5(INIT_5), .INIT_10(INIT_10),
        .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN), .ACK_TIMEOUT(ACK_TIMEOUT), .LOW_THRESH(LOW_THRESH)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int m5, m10;
    int ack_mode = 1;   // 0 none, 1 after pulse (ack_dly cycles late), 2 during last pulse cycle
    int ack_dly  = 0;

    // Pulse monitor: logs each ejected coin and flags bad pulse widths or overlap.
    int coin_log[$];
    int run5 = 0, run10 = 0, bad_len = 0, overlap = 0;
    always @(negedge clk) begin
        if (bus.out_5 && bus.out_10) overlap++;
        if (bus.out_10) run10++;
        else if (run10 > 0) begin
            coin_log.push_back(10);
            if (run10 != PULSE_LEN) bad_len++;
            run10 = 0;
        end
        if (bus.out_5) run5++;
        else if (run5 > 0) begin
            coin_log.push_back(5);
            if (run5 != PULSE_LEN) bad_len++;
            run5 = 0;
        end
    end

    initial begin
        int run, cd;
        bit prev_any, any, armed;
        run = 0; cd = 0; prev_any = 0; armed = 0;
        bus.hopper_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.hopper_ack = 1'b0;
            any = bus.out_5 | bus.out_10;
            if (!rst) begin
                armed = 0; run = 0;
            end else begin
                if (any) run++; else run = 0;
                if (ack_mode == 2 && any && run == PULSE_LEN) bus.hopper_ack = 1'b1;
                if (ack_mode == 1 && prev_any && !any) begin
                    armed = 1; cd = ack_dly;
                end
                if (armed) begin
                    if (cd == 0) begin
                        bus.hopper_ack = 1'b1;
                        armed = 0;
                    end else cd--;
                end
            end
            prev_any = any;
        end
    end

    function automatic void predict(input int amt, input int c5, input int c10,
                                    output bit ok, output int tens, output int fives);
        tens = amt / 10;
        if (tens > c10) tens = c10;
        fives = (amt - 10 * tens) / 5;
        ok = (amt % 5 == 0) && (fives <= c5);
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_amount = '0;
        bus.refill = 1'b0; bus.refill_5 = '0; bus.refill_10 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m5 = INIT_5; m10 = INIT_10;
    endtask

    task automatic do_request(input int amt, input bit rf, input int r5, input int r10,
                              output bit got_done, output bit got_err, output int lat);
        int n;
        got_done = 0; got_err = 0; lat = 0; n = 0;
        while (!bus.req_ready && n < 2000) begin
            @(negedge clk); n++;
        end
        bus.req_valid = 1'b1; bus.req_amount = AMT_W'(amt);
        bus.refill = rf; bus.refill_5 = CNT_W'(r5); bus.refill_10 = CNT_W'(r10);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.refill = 1'b0; bus.req_amount = AMT_W'($urandom);
        for (int i = 1; i <= 5000; i++) begin
            if (bus.done) got_done = 1;
            if (bus.err)  got_err = 1;
            if (got_done || got_err) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic count_coins(input int base, output int tens, output int fives);
        tens = 0; fives = 0;
        for (int i = base; i < coin_log.size(); i++) begin
            if (coin_log[i] == 10) tens++; else fives++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_amount = '0;
        bus.refill = 1'b0; bus.refill_5 = '0; bus.refill_10 = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if ({bus.out_5, bus.out_10, bus.done, bus.err} !== 4'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000", {bus.out_5, bus.out_10, bus.done, bus.err}); end
        checks++; if (bus.cnt_5 !== CNT_W'(INIT_5)) begin errors++; $display("FAIL reset_cnt5: got %0d want %0d", bus.cnt_5, INIT_5); end
        checks++; if (bus.cnt_10 !== CNT_W'(INIT_10)) begin errors++; $display("FAIL reset_cnt10: got %0d want %0d", bus.cnt_10, INIT_10); end
        checks++; if (bus.low_stock !== 1'b0) begin errors++; $display("FAIL reset_low: got %b want 0", bus.low_stock); end
        rst = 1'b1;
        @(negedge clk);
        m5 = INIT_5; m10 = INIT_10;
    endtask

    task automatic test_fifteen();
        bit d, e; int lat, base;
        ack_mode = 1; ack_dly = 0;
        base = coin_log.size();
        do_request(15, 0, 0, 0, d, e, lat);
        checks++; if ({d, e} !== 2'b10) begin errors++; $display("FAIL f15_outcome: got done=%b err=%b want done", d, e); end
        checks++; if (lat != 1 + 2 * (PULSE_LEN + 1 + GAP_LEN) + 1) begin errors++; $display("FAIL f15_latency: got %0d want %0d", lat, 2 + 2 * (PULSE_LEN + 1 + GAP_LEN)); end
        checks++; if (coin_log.size() - base != 2) begin errors++; $display("FAIL f15_ncoins: got %0d want 2", coin_log.size() - base); end
        else begin
            checks++; if (coin_log[base] != 10 || coin_log[base+1] != 5) begin errors++; $display("FAIL f15_order: got %0d,%0d want 10,5", coin_log[base], coin_log[base+1]); end
        end
        checks++; if (bus.cnt_10 !== 8'd19 || bus.cnt_5 !== 8'd19) begin errors++; $display("FAIL f15_counts: got %0d/%0d want 19/19", bus.cnt_10, bus.cnt_5); end
    endtask

    task automatic test_drain_tens();
        bit d, e; int lat, base, t, f;
        apply_reset();
        base = coin_log.size();
        do_request(200, 0, 0, 0, d, e, lat);
        count_coins(base, t, f);
        checks++; if (!d || e || t != 20 || f != 0) begin errors++; $display("FAIL drain200: got done=%b err=%b tens=%0d fives=%0d want done 20/0", d, e, t, f); end
        checks++; if (bus.cnt_10 !== 8'd0) begin errors++; $display("FAIL drain_cnt10: got %0d want 0", bus.cnt_10); end
        base = coin_log.size();
        do_request(20, 0, 0, 0, d, e, lat);
        count_coins(base, t, f);
        checks++; if (!d || e || t != 0 || f != 4) begin errors++; $display("FAIL fives20: got done=%b err=%b tens=%0d fives=%0d want done 0/4", d, e, t, f); end
        checks++; if (bus.cnt_5 !== 8'd16) begin errors++; $display("FAIL fives_cnt5: got %0d want 16", bus.cnt_5); end
    endtask

    task automatic test_bad_amount();
        bit d, e; int lat, base;
        logic [CNT_W-1:0] c5, c10;
        c5 = bus.cnt_5; c10 = bus.cnt_10; base = coin_log.size();
        do_request(7, 0, 0, 0, d, e, lat);
        checks++; if ({d, e} !== 2'b01 || lat != 2) begin errors++; $display("FAIL bad7: got done=%b err=%b lat=%0d want err at 2", d, e, lat); end
        repeat (3) @(negedge clk);
        checks++; if (coin_log.size() != base || bus.cnt_5 !== c5 || bus.cnt_10 !== c10) begin errors++; $display("FAIL bad7_state: got coins=%0d cnt=%0d/%0d want 0 %0d/%0d", coin_log.size() - base, bus.cnt_10, bus.cnt_5, c10, c5); end
    endtask

    task automatic test_insufficient();
        bit d, e; int lat, base;
        apply_reset();
        do_request(200, 0, 0, 0, d, e, lat);
        do_request(85, 0, 0, 0, d, e, lat);
        @(negedge clk);
        bus.refill = 1'b1; bus.refill_5 = '0; bus.refill_10 = 8'd1;
        @(negedge clk);
        bus.refill = 1'b0;
        checks++; if (bus.cnt_10 !== 8'd1 || bus.cnt_5 !== 8'd3) begin errors++; $display("FAIL insuf_setup: got %0d/%0d want 1/3", bus.cnt_10, bus.cnt_5); end
        base = coin_log.size();
        do_request(30, 0, 0, 0, d, e, lat);
        repeat (2) @(negedge clk);
        checks++; if ({d, e} !== 2'b01 || coin_log.size() != base) begin errors++; $display("FAIL insuf30: got done=%b err=%b coins=%0d want err 0", d, e, coin_log.size() - base); end
        checks++; if (bus.cnt_10 !== 8'd1 || bus.cnt_5 !== 8'd3) begin errors++; $display("FAIL insuf_counts: got %0d/%0d want 1/3", bus.cnt_10, bus.cnt_5); end
    endtask

    task automatic test_timeout();
        bit d, e; int lat;
        apply_reset();
        ack_mode = 0;
        do_request(10, 0, 0, 0, d, e, lat);
        checks++; if ({d, e} !== 2'b01) begin errors++; $display("FAIL tmo_outcome: got done=%b err=%b want err", d, e); end
        checks++; if (lat != 1 + PULSE_LEN + ACK_TIMEOUT + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", lat, PULSE_LEN + ACK_TIMEOUT + 2); end
        checks++; if (bus.cnt_10 !== CNT_W'(INIT_10) || bus.req_ready !== 1'b1) begin errors++; $display("FAIL tmo_state: got cnt10=%0d ready=%b want %0d 1", bus.cnt_10, bus.req_ready, INIT_10); end
        ack_mode = 1;
    endtask

    task automatic test_refill_sat();
        bit d, e; int lat;
        apply_reset();
        bus.refill = 1'b1; bus.refill_5 = 8'd250; bus.refill_10 = 8'd0;
        @(negedge clk);
        bus.refill = 1'b0;
        checks++; if (bus.cnt_5 !== 8'd255) begin errors++; $display("FAIL refill_sat: got %0d want 255", bus.cnt_5); end
        repeat (2) @(negedge clk);
        checks++; if (bus.low_stock !== 1'b0) begin errors++; $display("FAIL low_before: got %b want 0", bus.low_stock); end
        do_request(180, 0, 0, 0, d, e, lat);
        repeat (3) @(negedge clk);
        checks++; if (bus.cnt_10 !== 8'd2) begin errors++; $display("FAIL low_drain: got %0d want 2", bus.cnt_10); end
        checks++; if (bus.low_stock !== LOW_EN) begin errors++; $display("FAIL low_after: got %b want %b", bus.low_stock, LOW_EN); end
    endtask

    task automatic test_refill_with_req();
        bit d, e; int lat, base, t, f;
        apply_reset();
        do_request(200, 0, 0, 0, d, e, lat);
        base = coin_log.size();
        do_request(30, 1, 0, 3, d, e, lat);
        count_coins(base, t, f);
        checks++; if (!d || t != 3 || f != 0) begin errors++; $display("FAIL refill_req: got done=%b tens=%0d fives=%0d want done 3/0", d, t, f); end
        checks++; if (bus.cnt_10 !== 8'd0 || bus.cnt_5 !== 8'd20) begin errors++; $display("FAIL refill_req_cnt: got %0d/%0d want 0/20", bus.cnt_10, bus.cnt_5); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        apply_reset();
        ack_mode = 1; ack_dly = 0;
        bus.req_valid = 1'b1; bus.req_amount = 8'd20;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (bus.cnt_10 !== 8'd19) begin errors++; $display("FAIL mid_pre: got %0d want 19", bus.cnt_10); end
        rst = 1'b0;
        #1;
        checks++; if (bus.cnt_10 !== CNT_W'(INIT_10) || bus.req_ready !== 1'b1 || bus.out_10 !== 1'b0) begin errors++; $display("FAIL mid_reset: got cnt10=%0d ready=%b out10=%b want %0d 1 0", bus.cnt_10, bus.req_ready, bus.out_10, INIT_10); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.out_10 || bus.out_5) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_quiet: got activity=%b want 0", seen); end
        m5 = INIT_5; m10 = INIT_10;
    endtask

    task automatic test_random();
        bit d, e, ok, rf; int lat, base, t, f, et, ef, amt, r5, r10;
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            amt = $urandom_range(0, 24) * 5;
            if ($urandom_range(0, 4) == 0) amt = $urandom_range(0, 130);
            rf = ($urandom_range(0, 2) == 0);
            r5 = $urandom_range(0, 20); r10 = $urandom_range(0, 20);
            ack_mode = $urandom_range(1, 2); ack_dly = $urandom_range(0, 3);
            if (rf) begin
                m5  = (m5 + r5 > 255) ? 255 : m5 + r5;
                m10 = (m10 + r10 > 255) ? 255 : m10 + r10;
            end
            predict(amt, m5, m10, ok, et, ef);
            base = coin_log.size();
            do_request(amt, rf, r5, r10, d, e, lat);
            repeat (2) @(negedge clk);
            count_coins(base, t, f);
            if (ok) begin m10 -= et; m5 -= ef; end
            else begin et = 0; ef = 0; end
            checks++; if (d != ok || e != !ok) begin errors++; $display("FAIL rnd%0d_outcome amt=%0d: got done=%b err=%b want ok=%b", it, amt, d, e, ok); end
            checks++; if (t != et) begin errors++; $display("FAIL rnd%0d_tens amt=%0d: got %0d want %0d", it, amt, t, et); end
            checks++; if (f != ef) begin errors++; $display("FAIL rnd%0d_fives amt=%0d: got %0d want %0d", it, amt, f, ef); end
            checks++; if (int'(bus.cnt_10) != m10) begin errors++; $display("FAIL rnd%0d_cnt10: got %0d want %0d", it, bus.cnt_10, m10); end
            checks++; if (int'(bus.cnt_5) != m5) begin errors++; $display("FAIL rnd%0d_cnt5: got %0d want %0d", it, bus.cnt_5, m5); end
        end
        ack_mode = 1; ack_dly = 0;
    endtask

    task automatic test_pulse_shape();
        checks++; if (bad_len != 0) begin errors++; $display("FAIL pulse_len: got %0d bad pulses want 0", bad_len); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_fifteen();
        test_drain_tens();
        test_bad_amount();
        test_insufficient();
        test_timeout();
        test_refill_sat();
        test_refill_with_req();
        test_mid_reset();
        test_random();
        test_pulse_shape();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
- Money-out side of the coin vending path: coins come in as 5/10 pulses, change goes out as 5/10 pulses.
- Accepts a change-amount request and checks it against an internal coin inventory.
- Drives a coin hopper with timed eject pulses, greedy order: 10s first, then 5s.
- Sits between the credit/vend controller and the physical hopper; reports done or error per request.

Parameters:
- AMT_W, 8, width of requested amount in rupees.
- CNT_W, 8, width of each coin inventory counter.
- INIT_5, 20, 5-coin stock after reset.
- INIT_10, 20, 10-coin stock after reset.
- PULSE_LEN, 4, cycles each eject pulse is held high (>=1).
- GAP_LEN, 2, idle cycles between coins (>=1).
- ACK_TIMEOUT, 255, max cycles to wait for hopper_ack.
- LOW_THRESH, 3, low-stock threshold (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  change request strobe.
- req_amount  in  AMT_W  amount in rupees.
- req_ready  out  1  high only in IDLE.
- refill  in  1  inventory refill strobe.
- refill_5  in  CNT_W  5-coins added.
- refill_10  in  CNT_W  10-coins added.
- out_5  out  1  eject one 5-coin (level, PULSE_LEN cycles).
- out_10  out  1  eject one 10-coin.
- hopper_ack  in  1  hopper confirms coin dropped.
- done  out  1  one-cycle pulse, request complete.
- err  out  1  one-cycle pulse, request rejected or aborted.
- cnt_5, cnt_10  out  CNT_W each  current inventory.
- low_stock  out  1  see Optional Feature.

Behaviour:
- Reset (rst=0, async): state IDLE; out_5=out_10=done=err=0; req_ready=1; cnt_5=INIT_5; cnt_10=INIT_10; timers cleared; low_stock=0.
- Handshake: request accepted on the clk edge where req_valid&req_ready. Request held internally; req_amount may change afterwards.
- States: IDLE, CHECK, PULSE, WAIT_ACK, GAP, FIN.
- IDLE -> CHECK on accept.
- CHECK (1 cycle):
  - n10=min(amt/10, cnt_10); rem=amt-10*n10; n5=rem/5.
  - Reject if amt%5!=0 or n5>cnt_5: err pulse, back to IDLE, inventory unchanged.
  - amt==0: done pulse, no coins.
  - Otherwise load n10, n5 -> PULSE.
- PULSE:
  - Coin type is 10 if n10>0, else 5.
  - Matching out_* high for exactly PULSE_LEN cycles; never both high.
  - -> WAIT_ACK.
- WAIT_ACK:
  - On hopper_ack=1: decrement the matching n* and cnt_* -> GAP.
  - ack already high during PULSE counts as seen (latched).
  - No ack within ACK_TIMEOUT cycles: err pulse -> IDLE. Remaining coins abandoned; cnt_* reflect coins actually acked.
- GAP: GAP_LEN cycles -> PULSE if n10+n5>0, else FIN.
- FIN: done pulse -> IDLE.
- Latency, amount 15, stock ok, ack in first WAIT_ACK cycle: 1 CHECK + 2 coins*(PULSE_LEN+1+GAP_LEN) + 1 FIN.
- Refill: applied only in IDLE, saturating add at 2^CNT_W-1. Ignored in other states. Refill and req_valid in the same IDLE cycle: refill applied first; CHECK sees the updated counts.
- hopper_ack outside WAIT_ACK/PULSE ignored.
- rst low mid-dispense: immediate return to reset values; outstanding coins lost; no done/err.

Optional Feature:
- Macro COIN_LOW_WARN_EN.
- Defined: low_stock is registered high when cnt_5<LOW_THRESH or cnt_10<LOW_THRESH, updated every cycle.
- Undefined: low_stock tied 0; no comparator logic.
- Dispense behaviour identical either way.

Test Plan:
- Reset release, req 15 (amount 15), ack after 1 cycle each coin -> out_10 pulse then out_5 pulse, done; cnt_10=19, cnt_5=19.
- cnt_10=0 via refill-less drain; req 20 with cnt_5=20 -> four out_5 pulses, done, cnt_5=16.
- req 7 -> err pulse next cycle after CHECK, no out_* activity, counts unchanged.
- req 30, cnt_10=1, cnt_5=3 -> err (needs 4 fives), no coins ejected.
- req 10, hopper_ack never asserted -> err after ACK_TIMEOUT cycles, cnt_10 unchanged, req_ready=1.
- Refill 250+20 on cnt_5 with CNT_W=8 -> cnt_5=255. With COIN_LOW_WARN_EN, cnt_10 drained to 2 -> low_stock=1.
